// File: rtl/controle_avaliacao.sv
// Serial chromosome loader and phenotype evaluator: scores chrom_out against a target table.
// Define MELHOR_FITNESS_EN to track the best fitness since reset on melhor_fitness.
module controle_avaliacao #(
    parameter int unsigned CROM_W = 468,
    parameter int unsigned N_VET  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              carga_valid,
    input  logic              carga_bit,
    output logic              carga_ready,
    input  logic              inicia,
    output logic              ocupado,
    output logic              pronto,
    output logic [11:0]       fitness,
    output logic [11:0]       melhor_fitness,
    output logic [CROM_W-1:0] cromossomo,
    output logic [7:0]        chrom_in,
    input  logic [7:0]        chrom_out,
    output logic [7:0]        alvo_addr,
    input  logic [7:0]        alvo_dado
);

    localparam int unsigned CargaW = $clog2(CROM_W + 1);
    localparam int unsigned AvalW  = $clog2(N_VET + 2);

    localparam logic [CargaW-1:0] CargaUlt   = CargaW'(CROM_W - 1);
    localparam logic [AvalW-1:0]  VetUlt     = AvalW'(N_VET - 1);
    localparam logic [AvalW-1:0]  AcumUlt    = AvalW'(N_VET);
    localparam logic [AvalW-1:0]  AvalFim    = AvalW'(N_VET + 1);

    typedef enum logic [1:0] {
        StOcioso,
        StCarga,
        StAvalia,
        StFim
    } estado_e;

    estado_e estado_q, estado_d;

    logic [CROM_W-1:0] crom_q;
    logic              crom_valido_q;
    logic [CargaW-1:0] carga_cnt_q;
    logic [AvalW-1:0]  aval_cnt_q;
    logic [7:0]        vet_q;
    logic [7:0]        resp_q;
    logic [11:0]       acc_q;
    logic [11:0]       fitness_q;

    logic       carga_aceita;
    logic       carga_ultimo;
    logic       inicia_aceita;
    logic       aval_fim;
    logic       acumula;
    logic [7:0] iguais;
    logic [3:0] acertos;

    assign carga_aceita  = carga_valid & carga_ready;
    // A bit accepted in StOcioso starts a new load, so it is bit number one.
    assign carga_ultimo  = (estado_q == StOcioso) ? (CROM_W == 1) : (carga_cnt_q == CargaUlt);
    assign inicia_aceita = inicia & ~carga_valid & crom_valido_q & (estado_q == StOcioso);
    assign aval_fim      = (aval_cnt_q == AvalFim);
    // Response of vector k is registered at E(k+1) and summed at E(k+2).
    assign acumula       = (aval_cnt_q != '0) && (aval_cnt_q <= AcumUlt);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= StOcioso;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            StOcioso: begin
                if (carga_aceita) begin
                    estado_d = carga_ultimo ? StOcioso : StCarga;
                end else if (inicia_aceita) begin
                    estado_d = StAvalia;
                end
            end
            StCarga: begin
                if (carga_aceita && carga_ultimo) begin
                    estado_d = StOcioso;
                end
            end
            StAvalia: begin
                if (aval_fim) begin
                    estado_d = StFim;
                end
            end
            StFim:    estado_d = StOcioso;
            default:  estado_d = StOcioso;
        endcase
    end

    always_comb begin
        carga_ready = 1'b0;
        ocupado     = 1'b0;
        pronto      = 1'b0;
        unique case (estado_q)
            StOcioso, StCarga: carga_ready = 1'b1;
            StAvalia:          ocupado     = 1'b1;
            StFim:             pronto      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crom_q        <= '0;
            crom_valido_q <= 1'b0;
            carga_cnt_q   <= '0;
        end else if (carga_aceita) begin
            crom_q        <= {carga_bit, crom_q[CROM_W-1:1]};
            carga_cnt_q   <= (estado_q == StOcioso) ? CargaW'(1) : carga_cnt_q + CargaW'(1);
            crom_valido_q <= carga_ultimo;
        end
    end

    always_comb begin
        iguais  = ~(resp_q ^ alvo_dado);
        acertos = '0;
        for (int i = 0; i < 8; i++) begin
            acertos = acertos + {3'b000, iguais[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aval_cnt_q <= '0;
            vet_q      <= '0;
            resp_q     <= '0;
            acc_q      <= '0;
            fitness_q  <= '0;
        end else begin
            resp_q <= chrom_out;
            if (inicia_aceita) begin
                aval_cnt_q <= '0;
                vet_q      <= '0;
                acc_q      <= '0;
            end else if (estado_q == StAvalia) begin
                aval_cnt_q <= aval_cnt_q + AvalW'(1);
                if (aval_cnt_q < VetUlt) begin
                    vet_q <= vet_q + 8'd1;
                end
                if (acumula) begin
                    acc_q <= acc_q + {8'd0, acertos};
                end
                if (aval_fim) begin
                    fitness_q <= acc_q;
                end
            end
        end
    end

`ifdef MELHOR_FITNESS_EN
    logic [11:0] melhor_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            melhor_q <= '0;
        end else if ((estado_q == StAvalia) && aval_fim && (acc_q > melhor_q)) begin
            melhor_q <= acc_q;
        end
    end

    assign melhor_fitness = melhor_q;
`else
    assign melhor_fitness = 12'd0;
`endif

    assign cromossomo = crom_q;
    assign fitness    = fitness_q;
    assign chrom_in   = vet_q;
    assign alvo_addr  = vet_q;

endmodule

// File: doc/controle_avaliacao.md
CONTROLE_AVALIACAO -- requirements
Module: controle_avaliacao

Interface
REQ-001 SHALL have parameter CROM_W, default 468, meaning chromosome length in bits.
REQ-002 SHALL have parameter N_VET, default 256, meaning number of input vectors evaluated (2^8).
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports carga_valid  in  1 and carga_bit  in  1  serial chromosome bit stream, LSB (bit 0) first.
REQ-006 SHALL have port carga_ready  out  1  high when a load bit is accepted this cycle.
REQ-007 SHALL have port inicia  in  1  start-evaluation request.
REQ-008 SHALL have ports ocupado  out  1 and pronto  out  1  busy flag and one-cycle done pulse.
REQ-009 SHALL have port fitness  out  12  matching-bit count of last completed evaluation.
REQ-010 SHALL have port melhor_fitness  out  12  best fitness since reset (see Configuration).
REQ-011 SHALL have port cromossomo  out  CROM_W  configuration word driven to the phenotype.
REQ-012 SHALL have ports chrom_in  out  8 and chrom_out  in  8  phenotype stimulus and its combinational response.
REQ-013 SHALL have ports alvo_addr  out  8 and alvo_dado  in  8  target truth-table read port, data valid one cycle after address.

Function
REQ-014 SHALL implement states OCIOSO, CARGA, AVALIA, FIM.
REQ-015 SHALL assert carga_ready combinationally in OCIOSO and CARGA only; a bit is accepted on an edge with carga_valid and carga_ready high.
REQ-016 SHALL, per accepted bit, shift cromossomo right, inserting carga_bit at bit CROM_W-1, so that after CROM_W bits the first bit is at bit 0.
REQ-017 SHALL clear crom_valido and enter CARGA on the first accepted bit; after the CROM_W-th bit, set crom_valido and return to OCIOSO.
REQ-018 SHALL accept inicia only in OCIOSO with crom_valido set; otherwise ignore it with no side effect; carga_valid takes priority over inicia in the same cycle.
REQ-019 SHALL, on accepting inicia (edge E0), clear the accumulator, set chrom_in=0 and alvo_addr=0, and enter AVALIA; ocupado high from E0 until the pronto edge.
REQ-020 SHALL increment chrom_in and alvo_addr together each cycle through N_VET-1, then hold them.
REQ-021 SHALL register chrom_out one cycle and, on the following edge, add popcount(~(chrom_out_reg ^ alvo_dado)) to a 12-bit accumulator; vector k is accumulated at edge E(k+2).
REQ-022 SHALL, at edge E(N_VET+2) (E258 by default), load fitness from the accumulator, pulse pronto for exactly one cycle in FIM, and return to OCIOSO on the next edge.
REQ-023 SHALL keep cromossomo and crom_valido unchanged during AVALIA/FIM; a new inicia re-evaluates the same chromosome.
REQ-024 SHALL hold fitness between evaluations; maximum value 2048 fits without wrap.

Reset
REQ-025 SHALL, on rst high at a clock edge, in any state including mid-load or mid-evaluation, go to OCIOSO and clear cromossomo, crom_valido, accumulator, fitness, melhor_fitness, chrom_in, alvo_addr, ocupado, pronto to 0; no pronto is emitted for an aborted evaluation.

Configuration
REQ-026 SHALL, with macro MELHOR_FITNESS_EN defined, update melhor_fitness to fitness on each pronto edge where the new fitness is strictly greater than melhor_fitness.
REQ-027 SHALL, without MELHOR_FITNESS_EN, drive melhor_fitness constant 0 and contain no comparison logic.

Verification
REQ-028 SHALL load 468-bit pattern 0xA5-repeating serially -> cromossomo equals pattern exactly at the edge after the 468th bit, carga_ready low during a later AVALIA.
REQ-029 SHALL, with stub phenotype chrom_out=chrom_in and table alvo[k]=k, start -> pronto at E258, fitness=2048; table alvo[k]=~k -> fitness=0.
REQ-030 SHALL assert inicia after only 100 loaded bits -> ignored, ocupado stays 0, no pronto.
REQ-031 SHALL assert rst at E100 of an evaluation -> next cycle ocupado=0, fitness=0, no pronto; inicia then ignored until a full reload.
REQ-032 SHALL, with MELHOR_FITNESS_EN, run evaluations yielding 1024, 2048, 512 -> melhor_fitness 1024, 2048, 2048.
